// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID velocity controller: FSM state encoding,
// derived-width calculators and a signed clamp.
package pid_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StErr,
      StMp,
      StMi,
      StMd,
      StSum
   } pid_state_e;

   // Error width: difference of two unsigned W-bit values needs one extra sign bit.
   function automatic int unsigned calc_ew(input int unsigned w);
      return w + 1;
   endfunction

   // Integrator width holding +/-lim as a signed value.
   function automatic int unsigned calc_iw(input int unsigned lim);
      return $clog2(lim + 1) + 1;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Three gain*operand products summed: two guard bits cover the carries.
   function automatic int unsigned calc_accw(input int unsigned gw, input int unsigned mw);
      return gw + mw + 2;
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/pid_mul.sv
// Registered unsigned-gain by signed-operand multiply followed by a registered accumulate.
// 'first' marks the product that restarts the accumulation.
module pid_mul
   import pid_pkg::*;
#(
   parameter int unsigned GW   = 8,
   parameter int unsigned MW   = 13,
   parameter int unsigned ACCW = 23
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   en,
   input  logic                   first,
   input  logic [GW-1:0]          a,
   input  logic signed [MW-1:0]   b,
   output logic signed [ACCW-1:0] acc
);

   logic signed [ACCW-1:0] a_ext;
   logic signed [ACCW-1:0] b_ext;
   logic signed [ACCW-1:0] prod_q;
   logic signed [ACCW-1:0] acc_q;
   logic                   pvld_q;
   logic                   first_q;

   assign a_ext = ACCW'(a);
   assign b_ext = ACCW'(b);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prod_q  <= '0;
         acc_q   <= '0;
         pvld_q  <= 1'b0;
         first_q <= 1'b0;
      end else begin
         pvld_q  <= en;
         first_q <= first;
         if (en) begin
            prod_q <= a_ext * b_ext;
         end
         if (pvld_q) begin
            acc_q <= (first_q ? '0 : acc_q) + prod_q;
         end
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/pid_vel_ctrl.sv
// Multi-cycle PID velocity controller sharing one multiplier across P, I and D terms.
// Define PID_SLEW_EN to limit the per-sample output change to SLEW_MAX.
module pid_vel_ctrl
   import pid_pkg::*;
#(
   parameter int unsigned W        = 9,
   parameter int unsigned GW       = 8,
   parameter int unsigned FRAC     = 4,
   parameter int unsigned OUT_MAX  = 511,
`ifdef PID_SLEW_EN
   parameter int unsigned I_LIM    = 4095,
   parameter int unsigned SLEW_MAX = 32
`else
   parameter int unsigned I_LIM    = 4095
`endif
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          sample_valid,
   input  logic [W-1:0]  setpoint,
   input  logic [W-1:0]  feedback,
   input  logic [GW-1:0] kp,
   input  logic [GW-1:0] ki,
   input  logic [GW-1:0] kd,
   input  logic          clr_int,
   output logic [W-1:0]  out_vel,
   output logic          out_valid,
   output logic          busy,
   output logic          sat
);

   localparam int unsigned EW   = calc_ew(W);
   localparam int unsigned DW   = EW + 1;
   localparam int unsigned IW   = calc_iw(I_LIM);
   localparam int unsigned MW   = max_u(IW, DW);
   localparam int unsigned ACCW = calc_accw(GW, MW);

   pid_state_e state_q, state_d;

   logic [W-1:0]           sp_q, fb_q;
   logic [GW-1:0]          kp_q, ki_q, kd_q;
   logic signed [EW-1:0]   e_q, e_prev_q, e_cur;
   logic signed [DW-1:0]   de_q, de_cur;
   logic signed [IW-1:0]   i_q, i_new;
   logic                   busy_q, fin_q, out_valid_q, sat_q;
   logic [W-1:0]           out_vel_q, y_clamp, vel_nxt;
   logic                   hold, sat_nxt;
   int                     y_int;

   logic                   accept, clear, err_en, mul_en, mul_first;
   logic [GW-1:0]          mul_a;
   logic signed [MW-1:0]   mul_b;
   logic signed [ACCW-1:0] acc;

   // busy_q also covers the output-register cycle after SUM, so IDLE alone does not admit.
   assign accept = (state_q == StIdle) && !busy_q && sample_valid && !clr_int;
   assign clear  = (state_q == StIdle) && !busy_q && clr_int;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StErr;
         StErr:   state_d = StMp;
         StMp:    state_d = StMi;
         StMi:    state_d = StMd;
         StMd:    state_d = StSum;
         StSum:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      err_en    = 1'b0;
      mul_en    = 1'b0;
      mul_first = 1'b0;
      mul_a     = '0;
      mul_b     = '0;
      unique case (state_q)
         StErr: err_en = 1'b1;
         StMp: begin
            mul_en    = 1'b1;
            mul_first = 1'b1;
            mul_a     = kp_q;
            mul_b     = MW'(e_q);
         end
         StMi: begin
            mul_en = 1'b1;
            mul_a  = ki_q;
            mul_b  = MW'(i_q);
         end
         StMd: begin
            mul_en = 1'b1;
            mul_a  = kd_q;
            mul_b  = MW'(de_q);
         end
         default: ;
      endcase
   end

   always_comb begin
      e_cur  = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
      de_cur = {e_cur[EW-1], e_cur} - {e_prev_q[EW-1], e_prev_q};
      // Anti-windup: stop integrating further into a rail the output already sits on.
      hold   = ((out_vel_q == W'(OUT_MAX)) && (e_cur > 0)) || ((out_vel_q == '0) && (e_cur < 0));
      i_new  = hold ? i_q
                    : IW'(clamp(int'(i_q) + int'(e_cur), -int'(I_LIM), int'(I_LIM)));
      y_int   = int'(acc) >>> FRAC;
      y_clamp = W'(clamp(y_int, 0, int'(OUT_MAX)));
      sat_nxt = (y_int < 0) || (y_int > int'(OUT_MAX));
`ifdef PID_SLEW_EN
      vel_nxt = W'(int'(out_vel_q) + clamp(int'(y_clamp) - int'(out_vel_q),
                                           -int'(SLEW_MAX), int'(SLEW_MAX)));
`else
      vel_nxt = y_clamp;
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sp_q        <= '0;
         fb_q        <= '0;
         kp_q        <= '0;
         ki_q        <= '0;
         kd_q        <= '0;
         e_q         <= '0;
         de_q        <= '0;
         e_prev_q    <= '0;
         i_q         <= '0;
         busy_q      <= 1'b0;
         fin_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_vel_q   <= '0;
         sat_q       <= 1'b0;
      end else begin
         fin_q       <= (state_q == StSum);
         out_valid_q <= fin_q;
         if (accept) begin
            sp_q   <= setpoint;
            fb_q   <= feedback;
            kp_q   <= kp;
            ki_q   <= ki;
            kd_q   <= kd;
            busy_q <= 1'b1;
         end
         if (clear) begin
            i_q      <= '0;
            e_prev_q <= '0;
         end
         if (err_en) begin
            e_q  <= e_cur;
            de_q <= de_cur;
            i_q  <= i_new;
         end
         if (fin_q) begin
            out_vel_q <= vel_nxt;
            sat_q     <= sat_nxt;
            e_prev_q  <= e_q;
            busy_q    <= 1'b0;
         end
      end
   end

   pid_mul #(
      .GW  (GW),
      .MW  (MW),
      .ACCW(ACCW)
   ) u_mul (
      .CLK  (CLK),
      .RST  (RST),
      .en   (mul_en),
      .first(mul_first),
      .a    (mul_a),
      .b    (mul_b),
      .acc  (acc)
   );

   assign out_vel   = out_vel_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_pid_vel_ctrl.sv
// Directed self-checking bench for pid_vel_ctrl; expected values are hand-computed
// from the controller equations (PID_SLEW_EN selects the slew expectations).
module tb_pid_vel_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       sample_valid = 1'b0;
   logic       clr_int = 1'b0;
   logic [8:0] setpoint = '0;
   logic [8:0] feedback = '0;
   logic [7:0] kp = '0;
   logic [7:0] ki = '0;
   logic [7:0] kd = '0;
   logic [8:0] out_vel;
   logic       out_valid;
   logic       busy;
   logic       sat;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   pid_vel_ctrl u_dut (
      .CLK         (CLK),
      .RST         (RST),
      .sample_valid(sample_valid),
      .setpoint    (setpoint),
      .feedback    (feedback),
      .kp          (kp),
      .ki          (ki),
      .kd          (kd),
      .clr_int     (clr_int),
      .out_vel     (out_vel),
      .out_valid   (out_valid),
      .busy        (busy),
      .sat         (sat)
   );

   // Drives one sample and returns the number of cycles from acceptance to out_valid (-1: none).
   task automatic run_sample(input int sp, input int fb, input int p, input int i, input int d,
                             output int lat);
      @(negedge CLK);
      setpoint     = 9'(sp);
      feedback     = 9'(fb);
      kp           = 8'(p);
      ki           = 8'(i);
      kd           = 8'(d);
      sample_valid = 1'b1;
      @(negedge CLK);
      sample_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge CLK);
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic pulse_clr();
      @(negedge CLK);
      clr_int = 1'b1;
      @(negedge CLK);
      clr_int = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      checks += 4;
      if (out_vel !== 9'd0) begin errors++; $display("FAIL reset out_vel: got %0d want 0", out_vel); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
      if (sat !== 1'b0) begin errors++; $display("FAIL reset sat: got %b want 0", sat); end
      RST = 1'b0;
   endtask

   task automatic test_p_only();
      int lat;
      pulse_clr();
      run_sample(300, 200, 16, 0, 0, lat);
      checks += 3;
      if (lat != 6) begin errors++; $display("FAIL p_only latency: got %0d want 6", lat); end
      if (out_vel !== 9'd100) begin errors++; $display("FAIL p_only out_vel: got %0d want 100", out_vel); end
      if (sat !== 1'b0) begin errors++; $display("FAIL p_only sat: got %b want 0", sat); end
      @(negedge CLK);
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL p_only pulse width: got %b want 0", out_valid); end
      if (out_vel !== 9'd100) begin errors++; $display("FAIL p_only hold: got %0d want 100", out_vel); end
      if (busy !== 1'b0) begin errors++; $display("FAIL p_only busy: got %b want 0", busy); end
   endtask

   task automatic test_clamp();
      int lat;
      run_sample(0, 300, 64, 0, 0, lat);
      checks += 2;
      if (out_vel !== 9'd0) begin errors++; $display("FAIL clamp_low out_vel: got %0d want 0", out_vel); end
      if (sat !== 1'b1) begin errors++; $display("FAIL clamp_low sat: got %b want 1", sat); end
      run_sample(300, 0, 64, 0, 0, lat);
      checks += 2;
      if (out_vel !== 9'd511) begin errors++; $display("FAIL clamp_high out_vel: got %0d want 511", out_vel); end
      if (sat !== 1'b1) begin errors++; $display("FAIL clamp_high sat: got %b want 1", sat); end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge CLK);
      setpoint     = 9'd300;
      feedback     = 9'd0;
      kp           = 8'd16;
      sample_valid = 1'b1;
      @(negedge CLK);
      sample_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid busy after accept: got %b want 1", busy); end
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b want 0", busy); end
      if (out_vel !== 9'd0) begin errors++; $display("FAIL reset_mid out_vel: got %0d want 0", out_vel); end
      if (sat !== 1'b0) begin errors++; $display("FAIL reset_mid sat: got %b want 0", sat); end
      seen = 0;
      repeat (12) begin
         @(negedge CLK);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL reset_mid out_valid count: got %0d want 0", seen); end
   endtask

   task automatic test_integrator();
      int lat;
      int exp_v [7] = '{100, 200, 300, 400, 500, 511, 511};
      bit exp_s [7] = '{0, 0, 0, 0, 0, 1, 1};
      pulse_clr();
      for (int k = 0; k < 7; k++) begin
         run_sample(100, 0, 0, 16, 0, lat);
         checks += 2;
         if (out_vel !== 9'(exp_v[k])) begin
            errors++;
            $display("FAIL integ step %0d out_vel: got %0d want %0d", k, out_vel, exp_v[k]);
         end
         if (sat !== exp_s[k]) begin
            errors++;
            $display("FAIL integ step %0d sat: got %b want %b", k, sat, exp_s[k]);
         end
      end
      // Held integrator (600) minus 100 gives 500; a wound-up one would stay clamped.
      run_sample(0, 100, 0, 16, 0, lat);
      checks += 2;
      if (out_vel !== 9'd500) begin errors++; $display("FAIL integ unwind out_vel: got %0d want 500", out_vel); end
      if (sat !== 1'b0) begin errors++; $display("FAIL integ unwind sat: got %b want 0", sat); end
   endtask

   task automatic test_derivative();
      int lat;
      pulse_clr();
      run_sample(20, 0, 0, 0, 16, lat);
      checks++;
      if (out_vel !== 9'd20) begin errors++; $display("FAIL deriv first out_vel: got %0d want 20", out_vel); end
      run_sample(20, 0, 0, 0, 16, lat);
      checks++;
      if (out_vel !== 9'd0) begin errors++; $display("FAIL deriv second out_vel: got %0d want 0", out_vel); end
   endtask

   task automatic test_back_to_back();
      int seen;
      int lat;
      @(negedge CLK);
      setpoint     = 9'd300;
      feedback     = 9'd200;
      kp           = 8'd16;
      ki           = 8'd0;
      kd           = 8'd0;
      sample_valid = 1'b1;
      @(negedge CLK);
      sample_valid = 1'b0;
      @(negedge CLK);
      setpoint     = 9'd400;
      feedback     = 9'd0;
      sample_valid = 1'b1;
      @(negedge CLK);
      sample_valid = 1'b0;
      seen = 0;
      repeat (16) begin
         @(negedge CLK);
         if (out_valid) seen++;
      end
      checks += 2;
      if (seen != 1) begin errors++; $display("FAIL busy_drop out_valid count: got %0d want 1", seen); end
      if (out_vel !== 9'd100) begin errors++; $display("FAIL busy_drop out_vel: got %0d want 100", out_vel); end
      run_sample(400, 0, 16, 0, 0, lat);
      checks += 2;
      if (lat != 6) begin errors++; $display("FAIL back_to_back latency: got %0d want 6", lat); end
      if (out_vel !== 9'd400) begin errors++; $display("FAIL back_to_back out_vel: got %0d want 400", out_vel); end
   endtask

   task automatic test_clr_drop();
      int seen;
      @(negedge CLK);
      setpoint     = 9'd50;
      feedback     = 9'd0;
      clr_int      = 1'b1;
      sample_valid = 1'b1;
      @(negedge CLK);
      clr_int      = 1'b0;
      sample_valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL clr_drop busy: got %b want 0", busy); end
      seen = 0;
      repeat (12) begin
         @(negedge CLK);
         if (out_valid) seen++;
      end
      checks += 2;
      if (seen != 0) begin errors++; $display("FAIL clr_drop out_valid count: got %0d want 0", seen); end
      if (out_vel !== 9'd400) begin errors++; $display("FAIL clr_drop out_vel: got %0d want 400", out_vel); end
   endtask

   task automatic test_slew();
      int lat;
`ifdef PID_SLEW_EN
      int exp_v [4] = '{32, 64, 96, 100};
`else
      int exp_v [4] = '{100, 100, 100, 100};
`endif
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 0; k < 4; k++) begin
         run_sample(100, 0, 16, 0, 0, lat);
         checks += 2;
         if (out_vel !== 9'(exp_v[k])) begin
            errors++;
            $display("FAIL slew step %0d out_vel: got %0d want %0d", k, out_vel, exp_v[k]);
         end
         if (sat !== 1'b0) begin
            errors++;
            $display("FAIL slew step %0d sat: got %b want 0", k, sat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_p_only();
      test_clamp();
      test_reset_mid();
      test_integrator();
      test_derivative();
      test_back_to_back();
      test_clr_drop();
      test_slew();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1);
   end

endmodule

// File: doc/pid_vel_ctrl.md
Name: pid_vel_ctrl

Overview:
Parametrised, multi-cycle PID velocity controller for the BLDC speed loop. It sits between the hall/encoder speed estimator (feedback) and the PWM duty generator (out_vel). One shared multiplier is time-multiplexed by an FSM, giving one update per accepted sample. It adds runtime gains, a clamped integrator with anti-windup, a derivative term and output saturation.

Parameters:
W, 9, width of setpoint, feedback and out_vel (unsigned)
GW, 8, width of kp/ki/kd (unsigned, fixed-point with FRAC fractional bits)
FRAC, 4, fractional bits of the gains; the result is arithmetically shifted right by FRAC (floor)
OUT_MAX, 511, upper output clamp (lower clamp fixed at 0)
I_LIM, 4095, integrator magnitude clamp, symmetric (±I_LIM)
SLEW_MAX, 32, maximum output change per sample (used only with PID_SLEW_EN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
sample_valid  in  1  one-cycle strobe: setpoint and feedback are valid
setpoint  in  W  target velocity
feedback  in  W  measured velocity
kp, ki, kd  in  GW each  gains; sampled at acceptance
clr_int  in  1  synchronous clear of integrator and e_prev; takes priority over accepting a sample
out_vel  out  W  controller output, held between updates
out_valid  out  1  one-cycle pulse when out_vel updates
busy  out  1  high from acceptance until out_valid
sat  out  1  last output was clamped (at 0 or OUT_MAX); held until the next update

Behaviour:
- Reset (async): out_vel=0, out_valid=0, busy=0, sat=0, integrator=0, e_prev=0, FSM=IDLE. RST mid-operation aborts the computation; no out_valid is issued.
- FSM: IDLE -> ERR -> MP -> MI -> MD -> SUM -> IDLE.
- IDLE: on sample_valid with clr_int=0, latch inputs and gains, set busy, go to ERR. sample_valid while busy is ignored (dropped, no queue).
- ERR: e = setpoint - feedback, signed W+1 bits; de = e - e_prev.
- ERR, integrator update: I_new = clamp(I + e, ±I_LIM).
  - Anti-windup: hold I if the previous output was at OUT_MAX with e>0, or at 0 with e<0.
- MP / MI / MD: shared signed multiplier computes kp*e, ki*I_new and kd*de; the accumulator is wide enough that no overflow is possible.
- SUM: y = acc >>> FRAC, then clamp to [0, OUT_MAX]. Register out_vel and sat, set e_prev=e, pulse out_valid, clear busy.
- Latency: sample accepted at edge k; out_valid is high in the cycle after edge k+6. Throughput is at most one sample per 6 cycles.
- clr_int in IDLE: integrator=0 and e_prev=0 on the next edge; the simultaneous sample_valid is dropped. clr_int while busy is ignored.

Optional Feature:
PID_SLEW_EN
- Defined: after clamping, |out_vel_new - out_vel_old| is limited to SLEW_MAX. sat reflects the clamp only, not the slew limit.
- Undefined: out_vel takes the clamped value directly, and the SLEW_MAX logic is absent.

Decomposition:
- Package pid_pkg holds:
  - FSM state enum
  - derived widths (EW=W+1, IW for ±I_LIM, ACCW=GW+IW+2)
  - saturate/clamp function
- One sub-module, pid_mul: registered signed-by-unsigned multiply-accumulate, shared across MP/MI/MD.

Test Plan:
1. Reset: assert RST mid-computation -> out_vel=0, out_valid never pulses, busy=0 next cycle.
2. P-only: kp=16, ki=kd=0, sp=300, fb=200 -> out_vel=100, out_valid exactly 6 cycles after accept, sat=0.
3. Clamp, both directions:
   - kp=64, sp=300, fb=0 -> out_vel=511, sat=1.
   - sp=0, fb=300 -> out_vel=0, sat=1.
4. Integrator and anti-windup: kp=kd=0, ki=16, e=+100 repeated -> outputs 100, 200, 300, 400, 500, 511(sat), 511.
   - The integrator holds at 600 during the saturated samples.
   - Then e=-100 -> out_vel=500.
5. Derivative: kd=16, kp=ki=0, after clr_int, e=20 then e=20 -> out_vel=20, then 0.
6. Busy drop / slew:
   - A second sample_valid 2 cycles after accept -> only one out_valid.
   - With PID_SLEW_EN, SLEW_MAX=32, P target 100 from 0 -> 32, 64, 96, 100.
